// File: rtl/xpr_wb_merge.sv
// Writeback merge ahead of the XPR register file: ex -> wrt0, mem -> wrt1.
// Buffers load results, squashes WAW-stale mem writes, exports pending mask.
module xpr_wb_merge #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ex_valid,
  input  logic [AW-1:0]             ex_addr,
  input  logic [DW-1:0]             ex_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [AW-1:0]             mem_addr,
  input  logic [DW-1:0]             mem_data,
  output logic                      wrt0_WE,
  output logic [AW-1:0]             wrt0_WA,
  output logic [DW-1:0]             wrt0_D,
  output logic                      wrt1_WE,
  output logic [AW-1:0]             wrt1_WA,
  output logic [DW-1:0]             wrt1_D,
  output logic [(2**AW)-1:0]        pending,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_sq;
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;

  logic          w_kill;
  logic          w_push;
  logic          w_empty;
  logic          w_pop;
  logic          w_wr;
  logic          w_in_sq;
  logic          w_src_vld;
  logic [AW-1:0] w_src_addr;
  logic [DW-1:0] w_src_data;
  logic          w_src_sq;
  logic          w_src_hit;

  assign w_kill  = ex_valid && (ex_addr != '0);
  assign mem_ready = (r_cnt < CW'(DEPTH));
  assign w_push  = mem_valid && mem_ready;
  assign w_empty = (r_cnt == '0);
  assign w_pop   = !w_empty;
  // An empty FIFO lets the incoming load fall straight into wrt1.
  assign w_wr    = w_push && !w_empty;
  assign w_in_sq = (mem_addr == '0) || (w_kill && (mem_addr == ex_addr));

  assign w_src_vld  = w_pop || w_push;
  assign w_src_addr = w_empty ? mem_addr : r_addr[r_rp];
  assign w_src_data = w_empty ? mem_data : r_data[r_rp];
  assign w_src_sq   = w_empty ? (mem_addr == '0) : r_sq[r_rp];
  assign w_src_hit  = w_kill && (w_src_addr == ex_addr);

  assign fifo_count = r_cnt;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sq  <= '0;
      r_vld <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_kill && (r_addr[i] == ex_addr)) r_sq[i] <= 1'b1;
      end
      if (w_wr) begin
        r_addr[r_wp] <= mem_addr;
        r_data[r_wp] <= mem_data;
        r_sq[r_wp]   <= w_in_sq;
        r_vld[r_wp]  <= 1'b1;
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_wr) - CW'(w_pop);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wrt0_WE <= 1'b0;
      wrt0_WA <= '0;
      wrt0_D  <= '0;
      wrt1_WE <= 1'b0;
      wrt1_WA <= '0;
      wrt1_D  <= '0;
    end else begin
      wrt0_WE <= w_kill;
      wrt0_WA <= ex_addr;
      wrt0_D  <= ex_data;
      wrt1_WE <= w_src_vld && !w_src_sq && !w_src_hit;
      wrt1_WA <= w_src_addr;
      wrt1_D  <= w_src_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && !r_sq[i]) pending[r_addr[i]] = 1'b1;
    end
    if (wrt1_WE) pending[wrt1_WA] = 1'b1;
    pending[0] = 1'b0;
  end

endmodule
